led_row_scanner: RTL and testbench

Multiplexed 8x8 LED-matrix scanner for the Game of Life display. It accepts a full 64-cell board snapshot through a valid/ready handshake and double-buffers it. It then walks rows 0..7 with a programmable dwell time and a blanking gap between rows. Its outputs are the 3-bit row select and row enable that feed the downstream 3-to-8 row decoder, plus the 8-bit column data for the lit row.

---
 rtl/led_matrix_pkg.sv | 37 +++
 rtl/led_row_scanner_dwell_timer.sv | 33 +++
 rtl/led_row_scanner.sv | 173 +++++++++++++++++
 tb/tb_led_row_scanner.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/led_matrix_pkg.sv
// Shared types and constants for the 8x8 LED matrix display path.
// Contents: matrix geometry, row payload type, scanner state type,
// and small helpers used by the row scanner.
package led_matrix_pkg;

    localparam int unsigned ROWS    = 8;
    localparam int unsigned COLS    = 8;
    localparam int unsigned ROW_W   = $clog2(ROWS);
    localparam int unsigned FRAME_W = ROWS * COLS;

    typedef logic [COLS-1:0] row_bits_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BLANK,
        S_DRIVE
    } scan_state_t;

    // Larger of two tick counts; sizes the shared dwell counter.
    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    // Extract the column bits of one row; bit 8*r+c of the frame is cell (r,c).
    function automatic row_bits_t frame_row(input logic [FRAME_W-1:0] frame,
                                            input logic [ROW_W-1:0]   row);
        row_bits_t bits;
        bits = '0;
        for (int unsigned i = 0; i < ROWS; i++) begin
            if (row == ROW_W'(i)) begin
                bits = frame[i*COLS +: COLS];
            end
        end
        return bits;
    endfunction

endpackage

// File: rtl/led_row_scanner_dwell_timer.sv
// dwell_timer: loadable down-counter timing the BLANK and DRIVE phases.
// Ports:
//   clk          system clock
//   rst          synchronous active-low reset (counter cleared)
//   i_load       reload the counter this edge
//   i_load_val   value to load (phase length minus one)
//   o_expired_c  high while the counter is at zero, i.e. last cycle of a phase
module dwell_timer #(
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    output logic             o_expired_c
);

    logic [CNT_W-1:0] r_count;

    // Count down to zero and hold there until the next load.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (r_count != '0) begin
            r_count <= r_count - CNT_W'(1);
        end
    end

    assign o_expired_c = (r_count == '0);

endmodule

// File: rtl/led_row_scanner.sv
// led_row_scanner: double-buffered 8x8 LED matrix row scanner.
// Accepts a 64-cell frame over valid/ready into a shadow buffer, swaps it
// into the active buffer at frame boundaries, and walks rows 0..7 with a
// blanking gap (BLANK_TICKS) followed by a drive phase (CLK_TICKS_PER_ROW).
// Ports:
//   clk          system clock
//   rst          synchronous active-low reset
//   brightness   4-bit PWM duty (only when BRIGHTNESS_PWM_EN is defined)
//   frame_in     board snapshot, bit 8*r+c = cell (r,c)
//   frame_valid  frame_in holds a new frame
//   frame_ready  scanner can accept a frame (registered, = ~pending)
//   row_sel      current row index to the row decoder
//   row_ena      row decoder enable
//   col_data     column drive for the current row
//   frame_done   one-cycle pulse after row 7 finishes driving
// Build option: define BRIGHTNESS_PWM_EN to add the brightness PWM gate.
module led_row_scanner
    import led_matrix_pkg::*;
#(
    parameter int unsigned CLK_TICKS_PER_ROW = 1000,
    parameter int unsigned BLANK_TICKS       = 16
) (
    input  logic               clk,
    input  logic               rst,
`ifdef BRIGHTNESS_PWM_EN
    input  logic [3:0]         brightness,
`endif
    input  logic [FRAME_W-1:0] frame_in,
    input  logic               frame_valid,
    output logic               frame_ready,
    output logic [ROW_W-1:0]   row_sel,
    output logic               row_ena,
    output row_bits_t          col_data,
    output logic               frame_done
);

    localparam int unsigned MAX_TICKS = max_u(CLK_TICKS_PER_ROW, BLANK_TICKS);
    localparam int unsigned CNT_W     = $clog2(MAX_TICKS + 1);
    localparam logic        NO_BLANK  = (BLANK_TICKS == 0);
    localparam logic [CNT_W-1:0] DRIVE_LOAD = CNT_W'(CLK_TICKS_PER_ROW - 1);
    localparam logic [CNT_W-1:0] BLANK_LOAD =
        CNT_W'((BLANK_TICKS > 0) ? (BLANK_TICKS - 1) : 0);
    // Every row begins in BLANK unless blanking is disabled.
    localparam scan_state_t      ROW_START_STATE = NO_BLANK ? S_DRIVE : S_BLANK;
    localparam logic [CNT_W-1:0] ROW_START_LOAD  = NO_BLANK ? DRIVE_LOAD : BLANK_LOAD;

    scan_state_t        r_state;
    scan_state_t        w_state_next;
    logic [FRAME_W-1:0] r_active;
    logic [FRAME_W-1:0] r_shadow;
    logic               r_pending;
    logic [ROW_W-1:0]   w_row_next;
    logic               w_swap;
    logic               w_frame_end;
    logic               w_load;
    logic [CNT_W-1:0]   w_load_val;
    logic               w_expired;
    logic               w_accept;
    logic               w_pending_next;
    logic [FRAME_W-1:0] w_active_next;
    logic               w_drive_next;
    logic               w_ena_next;
    row_bits_t          w_col_next;

    dwell_timer #(
        .CNT_W(CNT_W)
    ) u_dwell_timer (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .o_expired_c(w_expired)
    );

    // Next-state logic: phase sequencing, row stepping, frame boundaries.
    always_comb begin
        w_state_next = r_state;
        w_row_next   = row_sel;
        w_swap       = 1'b0;
        w_frame_end  = 1'b0;
        w_load       = 1'b0;
        w_load_val   = DRIVE_LOAD;
        unique case (r_state)
            S_IDLE: begin
                if (r_pending) begin
                    w_swap       = 1'b1;
                    w_row_next   = '0;
                    w_load       = 1'b1;
                    w_load_val   = ROW_START_LOAD;
                    w_state_next = ROW_START_STATE;
                end
            end
            S_BLANK: begin
                if (w_expired) begin
                    w_load       = 1'b1;
                    w_load_val   = DRIVE_LOAD;
                    w_state_next = S_DRIVE;
                end
            end
            S_DRIVE: begin
                if (w_expired) begin
                    // Row index wraps 7 -> 0 naturally in ROW_W bits.
                    w_row_next   = row_sel + ROW_W'(1);
                    w_load       = 1'b1;
                    w_load_val   = ROW_START_LOAD;
                    w_state_next = ROW_START_STATE;
                    if (row_sel == ROW_W'(ROWS - 1)) begin
                        w_frame_end = 1'b1;
                        w_swap      = r_pending;
                    end
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Accept and swap never coincide: ready is low whenever pending is set.
    assign w_accept       = frame_valid & frame_ready;
    assign w_pending_next = w_accept | (r_pending & ~w_swap);
    assign w_active_next  = w_swap ? r_shadow : r_active;
    assign w_drive_next   = (w_state_next == S_DRIVE);
    assign w_col_next     = w_drive_next ? frame_row(w_active_next, w_row_next) : '0;

`ifdef BRIGHTNESS_PWM_EN
    logic [3:0] r_pwm;
    logic [3:0] w_pwm_next;

    // PWM phase restarts at every entry into DRIVE, free-runs mod 16 otherwise.
    assign w_pwm_next = (w_load && w_drive_next) ? 4'd0 : (r_pwm + 4'd1);
    assign w_ena_next = w_drive_next &&
                        ((w_pwm_next < brightness) || (brightness == 4'hF));

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_pwm <= 4'd0;
        end else begin
            r_pwm <= w_pwm_next;
        end
    end
`else
    assign w_ena_next = w_drive_next;
`endif

    // State, buffers and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_active    <= '0;
            r_shadow    <= '0;
            r_pending   <= 1'b0;
            row_sel     <= '0;
            row_ena     <= 1'b0;
            col_data    <= '0;
            frame_done  <= 1'b0;
            frame_ready <= 1'b1;
        end else begin
            r_state     <= w_state_next;
            r_active    <= w_active_next;
            r_pending   <= w_pending_next;
            row_sel     <= w_row_next;
            row_ena     <= w_ena_next;
            col_data    <= w_col_next;
            frame_done  <= w_frame_end;
            frame_ready <= ~w_pending_next;
            if (w_accept) begin
                r_shadow <= frame_in;
            end
        end
    end

endmodule

// File: tb/tb_led_row_scanner.sv
// Scoreboard bench for led_row_scanner: two instances (C=4/B=2 and C=1/B=0)
// share stimulus; a timeline model pushes expected outputs per cycle and a
// monitor on the falling edge pops and compares them.
module tb_led_row_scanner;

    typedef struct packed {
        logic [2:0] sel;
        logic       ena;
        logic [7:0] col;
        logic       done;
        logic       ready;
    } exp_t;

    localparam int unsigned NCFG = 2;
    localparam int unsigned CFG_C [NCFG] = '{4, 1};
    localparam int unsigned CFG_B [NCFG] = '{2, 0};

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] frame_in;
    logic        frame_valid;
`ifdef BRIGHTNESS_PWM_EN
    logic [3:0]  brightness;
`endif

    logic       a_ready, a_ena, a_done;
    logic [2:0] a_sel;
    logic [7:0] a_col;
    logic       b_ready, b_ena, b_done;
    logic [2:0] b_sel;
    logic [7:0] b_col;

    int checks = 0;
    int errors = 0;
    bit mon_en = 1'b0;

    exp_t q0[$];
    exp_t q1[$];

    always #5 clk = ~clk;

    led_row_scanner #(.CLK_TICKS_PER_ROW(4), .BLANK_TICKS(2)) u_dut_a (
        .clk(clk), .rst(rst),
`ifdef BRIGHTNESS_PWM_EN
        .brightness(brightness),
`endif
        .frame_in(frame_in), .frame_valid(frame_valid), .frame_ready(a_ready),
        .row_sel(a_sel), .row_ena(a_ena), .col_data(a_col), .frame_done(a_done)
    );

    led_row_scanner #(.CLK_TICKS_PER_ROW(1), .BLANK_TICKS(0)) u_dut_b (
        .clk(clk), .rst(rst),
`ifdef BRIGHTNESS_PWM_EN
        .brightness(brightness),
`endif
        .frame_in(frame_in), .frame_valid(frame_valid), .frame_ready(b_ready),
        .row_sel(b_sel), .row_ena(b_ena), .col_data(b_col), .frame_done(b_done)
    );

    // Reference model: scan position is just elapsed cycles modulo the frame period.
    bit          m_started [NCFG];
    int unsigned m_t       [NCFG];
    logic [63:0] m_shadow  [NCFG];
    logic [63:0] m_active  [NCFG];
    bit          m_pending [NCFG];
    bit          m_ready   [NCFG];
    int unsigned mp, mf, mph, mrow, mw;
    bit          m_end, m_acc;
    exp_t        m_e;

    always @(posedge clk) begin
        for (int k = 0; k < NCFG; k++) begin
            mp = CFG_B[k] + CFG_C[k];
            mf = 8 * mp;
            m_e = '0;
            if (!rst) begin
                m_started[k] = 1'b0;
                m_t[k]       = 0;
                m_shadow[k]  = '0;
                m_active[k]  = '0;
                m_pending[k] = 1'b0;
                m_ready[k]   = 1'b1;
            end else begin
                m_acc = frame_valid && m_ready[k];
                m_end = 1'b0;
                if (m_started[k]) begin
                    m_end = ((m_t[k] % mf) == mf - 1);
                    m_t[k] = m_t[k] + 1;
                    if (m_end && m_pending[k]) begin
                        m_active[k]  = m_shadow[k];
                        m_pending[k] = 1'b0;
                    end
                end else if (m_pending[k]) begin
                    m_started[k] = 1'b1;
                    m_t[k]       = 0;
                    m_active[k]  = m_shadow[k];
                    m_pending[k] = 1'b0;
                end
                if (m_acc) begin
                    m_shadow[k]  = frame_in;
                    m_pending[k] = 1'b1;
                end
                m_ready[k] = !m_pending[k];
                if (m_started[k]) begin
                    mph  = m_t[k] % mf;
                    mrow = mph / mp;
                    mw   = mph % mp;
                    m_e.sel  = 3'(mrow);
                    m_e.done = m_end;
                    if (mw >= CFG_B[k]) begin
                        m_e.col = m_active[k][mrow*8 +: 8];
                        m_e.ena = 1'b1;
`ifdef BRIGHTNESS_PWM_EN
                        m_e.ena = (((mw - CFG_B[k]) % 16) < brightness) || (brightness == 4'hF);
`endif
                    end
                end
            end
            m_e.ready = m_ready[k];
            if (k == 0) q0.push_back(m_e);
            else        q1.push_back(m_e);
        end
        mon_en <= 1'b1;
    end

    task automatic chk(input string name, input int k, input logic [7:0] act, input logic [7:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s dut%0d t=%0t actual=%0h required=%0h", name, k, $time, act, req);
        end
    endtask

    exp_t mon_e;
    exp_t mon_a;

    always @(negedge clk) begin
        if (mon_en) begin
            for (int k = 0; k < NCFG; k++) begin
                if ((k == 0 && q0.size() == 0) || (k == 1 && q1.size() == 0)) begin
                    checks++;
                    errors++;
                    $display("FAIL scoreboard_empty dut%0d t=%0t", k, $time);
                end else begin
                    if (k == 0) begin
                        mon_e = q0.pop_front();
                        mon_a = '{sel: a_sel, ena: a_ena, col: a_col, done: a_done, ready: a_ready};
                    end else begin
                        mon_e = q1.pop_front();
                        mon_a = '{sel: b_sel, ena: b_ena, col: b_col, done: b_done, ready: b_ready};
                    end
                    chk("row_sel",     k, 8'(mon_a.sel),   8'(mon_e.sel));
                    chk("row_ena",     k, 8'(mon_a.ena),   8'(mon_e.ena));
                    chk("col_data",    k, mon_a.col,       mon_e.col);
                    chk("frame_done",  k, 8'(mon_a.done),  8'(mon_e.done));
                    chk("frame_ready", k, 8'(mon_a.ready), 8'(mon_e.ready));
                end
            end
        end
    end

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    initial begin
        rst         = 1'b0;
        frame_valid = 1'b0;
        frame_in    = '0;
`ifdef BRIGHTNESS_PWM_EN
        brightness  = 4'd4;
`endif
        idle(3);
        rst = 1'b1;
        idle(20);

        // Diagonal frame, then long enough for two full frames of dut_a.
        frame_in    = 64'h8040201008040201;
        frame_valid = 1'b1;
        idle(1);
        frame_valid = 1'b0;
        idle(110);

        // Double buffer: all-ones, then all-zeros mid-frame, then held backpressure.
        frame_in    = '1;
        frame_valid = 1'b1;
        idle(1);
        frame_valid = 1'b0;
        idle(68);
        frame_in    = '0;
        frame_valid = 1'b1;
        idle(1);
        frame_in    = {$urandom, $urandom};
        idle(120);
        frame_valid = 1'b0;
        idle(60);

        // Reset in the middle of a scan; nothing may be redisplayed afterwards.
        idle(31);
        rst = 1'b0;
        idle(1);
        rst = 1'b1;
        idle(60);

        // Randomised traffic with occasional resets.
        for (int i = 0; i < 1500; i++) begin
            frame_valid = ($urandom_range(7) == 0);
            case ($urandom_range(3))
                0:       frame_in = '1;
                1:       frame_in = '0;
                default: frame_in = {$urandom, $urandom};
            endcase
            rst = ($urandom_range(399) != 0);
`ifdef BRIGHTNESS_PWM_EN
            if ($urandom_range(99) == 0) brightness = 4'($urandom_range(15));
`endif
            idle(1);
        end
        rst         = 1'b1;
        frame_valid = 1'b0;
        idle(4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
